// File: rtl/otter_div_unit_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
// DIV_abort exists only when OTTER_DIV_ABORT_EN is defined.
interface otter_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             DIV_start;
  logic [1:0]       DIV_op;
  logic [WIDTH-1:0] DIV_rs1;
  logic [WIDTH-1:0] DIV_rs2;
  logic [4:0]       DIV_wa_in;
`ifdef OTTER_DIV_ABORT_EN
  logic             DIV_abort;
`endif
  logic             DIV_busy;
  logic             DIV_done;
  logic             DIV_we;
  logic [4:0]       DIV_wa;
  logic [WIDTH-1:0] DIV_wd;

  modport master (
`ifdef OTTER_DIV_ABORT_EN
    output DIV_abort,
`endif
    output DIV_start, DIV_op, DIV_rs1, DIV_rs2, DIV_wa_in,
    input  DIV_busy, DIV_done, DIV_we, DIV_wa, DIV_wd
  );

  modport slave (
`ifdef OTTER_DIV_ABORT_EN
    input  DIV_abort,
`endif
    input  DIV_start, DIV_op, DIV_rs1, DIV_rs2, DIV_wa_in,
    output DIV_busy, DIV_done, DIV_we, DIV_wa, DIV_wd
  );
endinterface

// File: rtl/otter_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with registered write-back.
// Optional OTTER_DIV_ABORT_EN adds DIV_abort to cancel an operation in CALC or FIX.
module otter_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            DIV_CLK,
  input  logic            DIV_RST_N,
  otter_div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [1:0]       op;
  logic [4:0]       wa_pend;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] dvd, dvs, rem;

  logic             busy, done, we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;

  logic             is_signed, div_zero, overflow, special, abort, ge;
  logic [WIDTH-1:0] abs1, abs2, special_res, rem_sub, quo_fix, rem_fix, fix_res;
  logic [WIDTH:0]   trial;
  logic [4:0]       wa_load;

`ifdef OTTER_DIV_ABORT_EN
  assign abort = bus.DIV_abort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    is_signed   = ~bus.DIV_op[0];
    abs1        = (is_signed && bus.DIV_rs1[WIDTH-1]) ? -bus.DIV_rs1 : bus.DIV_rs1;
    abs2        = (is_signed && bus.DIV_rs2[WIDTH-1]) ? -bus.DIV_rs2 : bus.DIV_rs2;
    div_zero    = (bus.DIV_rs2 == '0);
    overflow    = is_signed && (bus.DIV_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.DIV_rs2 == '1);
    special     = div_zero || overflow;
    if (div_zero) special_res = bus.DIV_op[1] ? bus.DIV_rs1 : '1;
    else          special_res = bus.DIV_op[1] ? '0 : bus.DIV_rs1;

    // Partial remainder stays below the divisor, so the subtraction result fits WIDTH bits.
    trial   = {rem, dvd[WIDTH-1]};
    ge      = (trial >= {1'b0, dvs});
    rem_sub = trial[WIDTH-1:0] - dvs;

    quo_fix = neg_q ? -dvd : dvd;
    rem_fix = neg_r ? -rem : rem;
    fix_res = op[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.DIV_start) state_n = special ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && (state == CALC || state == FIX)) state_n = IDLE;
    wa_load = (state == IDLE) ? bus.DIV_wa_in : wa_pend;
  end

  always_ff @(posedge DIV_CLK) begin
    if (!DIV_RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      wa_pend <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      wa      <= '0;
      wd      <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      we    <= (state_n == DONE) && (wa_load != '0);
      case (state)
        IDLE: if (bus.DIV_start) begin
          op      <= bus.DIV_op;
          wa_pend <= bus.DIV_wa_in;
          neg_q   <= is_signed && (bus.DIV_rs1[WIDTH-1] ^ bus.DIV_rs2[WIDTH-1]);
          neg_r   <= is_signed && bus.DIV_rs1[WIDTH-1];
          dvd     <= abs1;
          dvs     <= abs2;
          rem     <= '0;
          cnt     <= CW'(WIDTH);
          if (special) begin
            wd <= special_res;
            wa <= bus.DIV_wa_in;
          end
        end
        // Quotient bits shift into the vacated low end of the dividend register.
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], ge};
          rem <= ge ? rem_sub : trial[WIDTH-1:0];
          cnt <= cnt - CW'(1);
        end
        FIX: if (state_n == DONE) begin
          wd <= fix_res;
          wa <= wa_pend;
        end
        default: ;
      endcase
    end
  end

  assign bus.DIV_busy = busy;
  assign bus.DIV_done = done;
  assign bus.DIV_we   = we;
  assign bus.DIV_wa   = wa;
  assign bus.DIV_wd   = wd;
endmodule

// File: tb/tb_otter_div_unit.sv
// Directed bench for otter_div_unit: scoreboard of RISC-V reference results, latency and protocol checks.
module tb_otter_div_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otter_div_unit_if #(.WIDTH(W)) bus ();
  otter_div_unit #(.WIDTH(W)) dut (.DIV_CLK(clk), .DIV_RST_N(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_wd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      2'b00:   return sa / sbv;
      2'b01:   return a / b;
      2'b10:   return sa % sbv;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic drive_idle();
    bus.DIV_start = 1'b0;
    bus.DIV_rs1   = $urandom;
    bus.DIV_rs2   = $urandom;
    bus.DIV_wa_in = 5'($urandom);
    bus.DIV_op    = 2'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input int restart_at);
    exp_t e, got_e;
    int   lat;
    bit   seen;
    e.wd  = ref_div(op, a, b);
    e.wa  = wa;
    e.we  = (wa != 5'd0);
    e.lat = is_special(op, a, b) ? 1 : int'(W) + 2;
    sb.push_back(e);
    @(negedge clk);
    bus.DIV_start = 1'b1;
    bus.DIV_op    = op;
    bus.DIV_rs1   = a;
    bus.DIV_rs2   = b;
    bus.DIV_wa_in = wa;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      drive_idle();
      if (lat == restart_at) begin
        bus.DIV_start = 1'b1;
        bus.DIV_op    = 2'b01;
        bus.DIV_rs1   = a ^ 32'h0000_5555;
        bus.DIV_rs2   = b + 32'd3;
        bus.DIV_wa_in = wa ^ 5'h1F;
      end
      if (bus.DIV_done === 1'b1) seen = 1'b1;
    end
    got_e = sb.pop_front();
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, lat, got_e.lat);
    check({tag, ".busy_at_done"}, 32'(bus.DIV_busy), 32'd1);
    check({tag, ".wd"}, bus.DIV_wd, got_e.wd);
    check({tag, ".wa"}, 32'(bus.DIV_wa), 32'(got_e.wa));
    check({tag, ".we"}, 32'(bus.DIV_we), 32'(got_e.we));
    @(posedge clk); #1;
    check({tag, ".done_drop"}, 32'(bus.DIV_done), 32'd0);
    check({tag, ".wd_hold"}, bus.DIV_wd, got_e.wd);
    last_wd = got_e.wd;
  endtask

  task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    @(negedge clk);
    bus.DIV_start = 1'b1;
    bus.DIV_op    = op;
    bus.DIV_rs1   = a;
    bus.DIV_rs2   = b;
    bus.DIV_wa_in = wa;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic watch_quiet(input string tag);
    int pulses;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.DIV_done !== 1'b0 || bus.DIV_we !== 1'b0) pulses++;
    end
    check({tag, ".no_done"}, pulses, 0);
  endtask

  initial begin
    bus.DIV_start = 1'b0;
    bus.DIV_op    = 2'b00;
    bus.DIV_rs1   = '0;
    bus.DIV_rs2   = '0;
    bus.DIV_wa_in = '0;
`ifdef OTTER_DIV_ABORT_EN
    bus.DIV_abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(bus.DIV_busy), 32'd0);
    check("reset.done", 32'(bus.DIV_done), 32'd0);
    check("reset.we",   32'(bus.DIV_we),   32'd0);
    check("reset.wa",   32'(bus.DIV_wa),   32'd0);
    check("reset.wd",   bus.DIV_wd,        32'd0);
    rst_n = 1'b1;

    run_op("divu_100_7",  2'b01, 32'd100,          32'd7,           5'd5,  0);
    run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,    32'd2,           5'd6,  0);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,    32'd2,           5'd7,  0);
    run_op("div_by0",     2'b00, 32'h1234_5678,    32'd0,           5'd8,  0);
    run_op("divu_by0",    2'b01, 32'h1234_5678,    32'd0,           5'd9,  0);
    run_op("remu_by0",    2'b11, 32'h1234_5678,    32'd0,           5'd10, 0);
    run_op("div_ovf",     2'b00, 32'h8000_0000,    32'hFFFF_FFFF,   5'd11, 0);
    run_op("rem_ovf",     2'b10, 32'h8000_0000,    32'hFFFF_FFFF,   5'd12, 0);
    run_op("rem_7_m3",    2'b10, 32'd7,            32'hFFFF_FFFD,   5'd13, 0);
    run_op("divu_max",    2'b01, 32'hFFFF_FFFF,    32'd1,           5'd14, 0);
    run_op("restart",     2'b01, 32'd1000000,      32'd37,          5'd15, 10);
    run_op("wa_zero",     2'b01, 32'd50,           32'd5,           5'd0,  0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      run_op("random", 2'(i % 4), a, b, 5'($urandom_range(1, 31)), 0);
    end

    start_only(2'b01, 32'd1000, 32'd3, 5'd9);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_calc.busy", 32'(bus.DIV_busy), 32'd0);
    check("rst_calc.done", 32'(bus.DIV_done), 32'd0);
    check("rst_calc.we",   32'(bus.DIV_we),   32'd0);
    check("rst_calc.wd",   bus.DIV_wd,        32'd0);
    rst_n = 1'b1;
    watch_quiet("rst_calc");
    run_op("after_rst", 2'b00, 32'hFFFF_FF9C, 32'd9, 5'd3, 0);

`ifdef OTTER_DIV_ABORT_EN
    start_only(2'b11, 32'd999, 32'd10, 5'd4);
    repeat (18) @(posedge clk);
    #1;
    bus.DIV_abort = 1'b1;
    @(posedge clk); #1;
    bus.DIV_abort = 1'b0;
    check("abort.busy", 32'(bus.DIV_busy), 32'd0);
    check("abort.done", 32'(bus.DIV_done), 32'd0);
    check("abort.wd",   bus.DIV_wd,        last_wd);
    watch_quiet("abort");
    run_op("after_abort", 2'b10, 32'd999, 32'd10, 5'd4, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
